// File: rtl/decode_pipe_ctrl.sv
// Three-stage decode pipeline sequencer: per-stage valid tracking, advance enables,
// micro-op expansion in stage 3. Optional perf counters under DECODE_PERF_CNT_EN.
module decode_pipe_ctrl #(
  parameter int instMinIdWidth = 4,
  parameter int STAGES         = 3
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      fetchValid_i,
  output logic                      fetchReady_o,
  output logic                      stage1En_o,
  output logic                      stage2En_o,
  output logic                      stage3En_o,
  input  logic [instMinIdWidth-1:0] uopCount_i,
  input  logic                      dispatchReady_i,
  output logic                      outValid_o,
  output logic [instMinIdWidth-1:0] minId_o,
  output logic                      lastUop_o,
  input  logic                      flush_i,
  output logic                      busy_o
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [0:31]               stallCycles_o,
  output logic [0:31]               uopsIssued_o
`endif
);

  localparam int W = instMinIdWidth;

  generate
    if (STAGES != 3) begin : g_stages_chk
      $error("decode_pipe_ctrl: STAGES must be 3");
    end
  endgenerate

  typedef enum logic {EMPTY, EMIT} st_t;

  st_t            st;
  logic [STAGES:1] vld_pipe;
  logic [W-1:0]   uop_idx, uop_last;
  logic           fire, last, live;
  logic           adv1, adv2, adv3;

  always_comb begin
    live         = !flush_i && !reset_i;
    fire         = vld_pipe[3] && dispatchReady_i;
    last         = (uop_idx == uop_last);
    // Back-pressure ripples from dispatch toward fetch in one cycle.
    adv3         = vld_pipe[2] && (!vld_pipe[3] || (fire && last));
    adv2         = vld_pipe[1] && (!vld_pipe[2] || adv3);
    fetchReady_o = live && (!vld_pipe[1] || adv2);
    adv1         = fetchValid_i && fetchReady_o;
    stage1En_o   = adv1 && live;
    stage2En_o   = adv2 && live;
    stage3En_o   = adv3 && live;
    outValid_o   = vld_pipe[3] && !reset_i;
    minId_o      = reset_i ? '0 : uop_idx;
    lastUop_o    = vld_pipe[3] && last && !reset_i;
    busy_o       = (|vld_pipe) && !reset_i;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || flush_i) begin
      vld_pipe <= '0;
      st       <= EMPTY;
      uop_idx  <= '0;
      uop_last <= '0;
    end else begin
      vld_pipe[1] <= adv1 || (vld_pipe[1] && !adv2);
      vld_pipe[2] <= adv2 || (vld_pipe[2] && !adv3);
      vld_pipe[3] <= adv3 || (vld_pipe[3] && !(fire && last));
      case (st)
        EMPTY: if (adv3) begin
          st       <= EMIT;
          uop_idx  <= '0;
          uop_last <= uopCount_i - 1'b1;  // count 0 means 2**W micro-ops
        end
        EMIT: if (fire) begin
          if (!last) uop_idx <= uop_idx + 1'b1;
          else if (adv3) begin
            uop_idx  <= '0;
            uop_last <= uopCount_i - 1'b1;
          end else st <= EMPTY;
        end
        default: st <= EMPTY;
      endcase
    end
  end

`ifdef DECODE_PERF_CNT_EN
  // Saturating counters; a micro-op dropped by flush is not counted as issued.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      stallCycles_o <= '0;
      uopsIssued_o  <= '0;
    end else begin
      if (fetchValid_i && !fetchReady_o && !flush_i && !(&stallCycles_o))
        stallCycles_o <= stallCycles_o + 32'd1;
      if (fire && !flush_i && !(&uopsIssued_o))
        uopsIssued_o <= uopsIssued_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_pipe_ctrl.sv
// Directed bench for decode_pipe_ctrl; perf counters exercised when DECODE_PERF_CNT_EN is defined.
module tb_decode_pipe_ctrl;
  logic       clock_i = 1'b0;
  logic       reset_i, fetchValid_i, dispatchReady_i, flush_i;
  logic [3:0] uopCount_i;
  logic       fetchReady_o, stage1En_o, stage2En_o, stage3En_o;
  logic       outValid_o, lastUop_o, busy_o;
  logic [3:0] minId_o;
`ifdef DECODE_PERF_CNT_EN
  logic [0:31] stallCycles_o, uopsIssued_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock_i = ~clock_i;

  decode_pipe_ctrl #(.instMinIdWidth(4), .STAGES(3)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .fetchValid_i(fetchValid_i),
    .fetchReady_o(fetchReady_o), .stage1En_o(stage1En_o), .stage2En_o(stage2En_o),
    .stage3En_o(stage3En_o), .uopCount_i(uopCount_i), .dispatchReady_i(dispatchReady_i),
    .outValid_o(outValid_o), .minId_o(minId_o), .lastUop_o(lastUop_o),
    .flush_i(flush_i), .busy_o(busy_o)
`ifdef DECODE_PERF_CNT_EN
    , .stallCycles_o(stallCycles_o), .uopsIssued_o(uopsIssued_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    fetchValid_i    = 1'b0;
    dispatchReady_i = 1'b1;
    while (busy_o && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy_o), 32'd0);
  endtask

  task automatic chk_no_en(input string tag);
    chk({tag, "_en1"}, 32'(stage1En_o), 32'd0);
    chk({tag, "_en2"}, 32'(stage2En_o), 32'd0);
    chk({tag, "_en3"}, 32'(stage3En_o), 32'd0);
  endtask

  initial begin
    int e_ov[6]   = '{0, 0, 0, 1, 1, 1};
    int e_id[6]   = '{0, 0, 0, 0, 1, 2};
    int e_last[6] = '{0, 0, 0, 0, 0, 1};
    int e_fr[6]   = '{1, 1, 1, 0, 0, 1};

    reset_i = 1'b1; fetchValid_i = 1'b1; dispatchReady_i = 1'b1;
    uopCount_i = 4'd1; flush_i = 1'b0;
    tick(); tick();
    chk("rst_fr",   32'(fetchReady_o), 32'd0);
    chk("rst_ov",   32'(outValid_o),   32'd0);
    chk("rst_busy", 32'(busy_o),       32'd0);
    chk("rst_id",   32'(minId_o),      32'd0);
    chk("rst_last", 32'(lastUop_o),    32'd0);
    chk_no_en("rst");

    // Back-to-back single-uop instructions.
    reset_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      fetchValid_i = (c < 4);
      #1;
      chk("t1_fr",   32'(fetchReady_o), 32'd1);
      chk("t1_ov",   32'(outValid_o),   32'(c >= 3 && c <= 6));
      chk("t1_id",   32'(minId_o),      32'd0);
      chk("t1_last", 32'(lastUop_o),    32'(c >= 3 && c <= 6));
      chk("t1_en1",  32'(stage1En_o),   32'(c < 4));
      tick();
    end
    drain("t1_drain", 4);

    // Three-uop instructions with fetch pushing behind.
    uopCount_i = 4'd3;
    for (int c = 0; c < 6; c++) begin
      fetchValid_i = (c < 3);
      #1;
      chk("t2_ov", 32'(outValid_o),   32'(e_ov[c]));
      chk("t2_fr", 32'(fetchReady_o), 32'(e_fr[c]));
      if (c >= 3) begin
        chk("t2_id",   32'(minId_o),   32'(e_id[c]));
        chk("t2_last", 32'(lastUop_o), 32'(e_last[c]));
      end
      tick();
    end
    drain("t2_drain", 20);

    // Dispatch stall with a full pipe, then release.
    uopCount_i = 4'd2; dispatchReady_i = 1'b0; fetchValid_i = 1'b1;
    tick(); tick(); tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t3_ov", 32'(outValid_o),   32'd1);
      chk("t3_id", 32'(minId_o),      32'd0);
      chk("t3_fr", 32'(fetchReady_o), 32'd0);
      chk_no_en("t3");
      tick();
    end
    dispatchReady_i = 1'b1; fetchValid_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("t3r_ov",   32'(outValid_o), 32'd1);
      chk("t3r_id",   32'(minId_o),    32'(k % 2));
      chk("t3r_last", 32'(lastUop_o),  32'(k % 2));
      tick();
    end
    chk("t3_empty", 32'(busy_o), 32'd0);

    // Count 0 expands to 16 micro-ops.
    uopCount_i = 4'd0; fetchValid_i = 1'b1;
    tick();
    fetchValid_i = 1'b0;
    tick(); tick();
    for (int k = 0; k < 16; k++) begin
      chk("t4_ov",   32'(outValid_o), 32'd1);
      chk("t4_id",   32'(minId_o),    32'(k));
      chk("t4_last", 32'(lastUop_o),  32'(k == 15));
      tick();
    end
    chk("t4_empty", 32'(busy_o), 32'd0);

    // Flush with all stages full, mid-instruction.
    uopCount_i = 4'd3; fetchValid_i = 1'b1;
    tick(); tick(); tick(); tick();
    flush_i = 1'b1;
    #1;
    chk("t5_pre_id",   32'(minId_o),      32'd1);
    chk("t5_pre_busy", 32'(busy_o),       32'd1);
    chk("t5_fl_fr",    32'(fetchReady_o), 32'd0);
    chk_no_en("t5_fl");
    tick();
    flush_i = 1'b0;
    #1;
    chk("t5_busy", 32'(busy_o),       32'd0);
    chk("t5_ov",   32'(outValid_o),   32'd0);
    chk("t5_fr",   32'(fetchReady_o), 32'd1);
    tick();
    fetchValid_i = 1'b0;
    chk("t5_ov1", 32'(outValid_o), 32'd0);
    tick();
    chk("t5_ov2", 32'(outValid_o), 32'd0);
    tick();
    chk("t5_ov3", 32'(outValid_o), 32'd1);
    chk("t5_id3", 32'(minId_o),    32'd0);
    drain("t5_drain", 20);

    // Reset (with flush) mid-emission discards the instruction.
    fetchValid_i = 1'b1;
    tick();
    fetchValid_i = 1'b0;
    tick(); tick(); tick();
    chk("t6_pre_id", 32'(minId_o), 32'd1);
    reset_i = 1'b1; flush_i = 1'b1;
    #1;
    chk("t6_rst_ov", 32'(outValid_o), 32'd0);
    tick();
    reset_i = 1'b0; flush_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t6_ov",   32'(outValid_o), 32'd0);
      chk("t6_busy", 32'(busy_o),     32'd0);
      tick();
    end

`ifdef DECODE_PERF_CNT_EN
    reset_i = 1'b1; fetchValid_i = 1'b0;
    tick();
    reset_i = 1'b0; dispatchReady_i = 1'b0; uopCount_i = 4'd2; fetchValid_i = 1'b1;
    for (int c = 0; c < 7; c++) tick();
    drain("t7_drain", 20);
    chk("t7_stall", stallCycles_o, 32'd4);
    chk("t7_uops",  uopsIssued_o,  32'd6);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
